sar_conv_ctrl: RTL and testbench
================================

Name: sar_conv_ctrl

Overview:
Conversion sequencer for the charge-redistribution SAR ADC.
- On a start request it drives the sample phase and then runs an MSB-first successive approximation over the DAC switch vectors B/BN. It waits a programmable settle time per bit and samples the dynamic comparator outputs.
- Presents the final code with a one-cycle done pulse.
- Sits between the system-side conversion request logic and the capacitor DAC / comparator macro.

Parameters:
- N_BITS, 8, resolution; width of B, BN, result.
- SAMPLE_CYC, 2, cycles sample is held high (min 1).
- SETTLE_CYC, 1, DAC settle cycles before each comparator decision (min 1).

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous active-high reset
- start  in  1  conversion request; sampled only in IDLE
- cmp_p  in  1  comparator: input above DAC level
- cmp_m  in  1  comparator: input below DAC level
- sample  out  1  track/hold switch control
- cmp_en  out  1  comparator clock enable; high only in DECIDE
- B  out  N_BITS  DAC switch vector (1 = bit to Vref)
- BN  out  N_BITS  complement switch vector; always equal to ~B
- busy  out  1  conversion in progress
- done  out  1  one-cycle pulse, result valid
- result  out  N_BITS  last completed code; held until next done

Behaviour:
- Reset (rst high at a rising edge): next cycle state = IDLE, B = 0, BN = all ones, result = 0, sample = busy = done = cmp_en = 0. Reset applies from any state, including mid-conversion; no done is produced for an aborted conversion.
- FSM states: IDLE, SAMPLE, SETTLE, DECIDE, DONE.
- IDLE:
  - B = 0, BN = all ones.
  - If start = 1, go to SAMPLE. Load the timer with SAMPLE_CYC-1 and set the bit index to N_BITS-1.
- SAMPLE:
  - sample = 1, busy = 1, B = 0.
  - When the timer reaches 0, set B[N_BITS-1] = 1 and go to SETTLE with the timer at SETTLE_CYC-1.
- SETTLE:
  - busy = 1; the trial bit is applied.
  - When the timer reaches 0, go to DECIDE.
- DECIDE: one cycle, cmp_en = 1, busy = 1. Comparator sampled at the end of the cycle:
  - cmp_p = 1: keep B[idx] = 1 (cmp_p has priority over cmp_m).
  - cmp_p = 0, any cmp_m: clear B[idx]. The "neither asserted" case also resolves to 0.
  - If idx > 0: decrement idx, set B[idx-1] = 1, return to SETTLE with the timer at SETTLE_CYC-1.
  - If idx = 0: result <= final B, go to DONE.
- DONE:
  - done = 1 for exactly one cycle, busy = 0.
  - Always returns to IDLE; start during DONE is ignored.
- Latency: start accepted at edge t; done high during cycle t + SAMPLE_CYC + N_BITS*(SETTLE_CYC+1) + 1. With defaults, done is high in cycle t+19.
- start asserted while busy or in DONE: ignored, not queued. With start held high, conversions repeat with exactly one IDLE cycle between done and the next SAMPLE.
- BN is combinational ~B (or registered identically); it never differs from ~B in any cycle.
- Bit index is a $clog2(N_BITS) down-counter; no wrap, terminates at 0.

Optional Feature:
- Macro: SAR_CTRL_CMP_ERR_EN.
- Defined:
  - Adds output port cmp_err (1 bit), plus a sticky internal flag set in DECIDE when cmp_p == cmp_m (both or neither asserted).
  - cmp_err is valid with done and reflects any illegal decision during that conversion.
  - The flag is cleared on start acceptance and on rst; cmp_err = 0 out of reset.
- Undefined: no port, no flag; decision rules are unchanged.

Decomposition:
- Package sar_ctrl_pkg: state enum (IDLE, SAMPLE, SETTLE, DECIDE, DONE), default N_BITS/SAMPLE_CYC/SETTLE_CYC constants.
- One natural sub-module, sar_cycle_timer: a loadable down-counter with a zero flag, used for the SAMPLE and SETTLE durations. The bit-index counter and FSM stay in the top.

Test Plan:
- Ideal comparator model (cmp_p = Vin >= B, cmp_m = !cmp_p), Vin = 0xA5, pulse start -> done at start+19 cycles, result = 0xA5, BN = ~B in every cycle, busy high for 18 cycles.
- Vin = 0xFF and Vin = 0x00 -> result 0xFF / 0x00. For 0xFF, B sequence is 0x80, 0xC0, …, 0xFF.
- start pulsed again at cycles 5 and 19 after the first start -> both ignored, exactly one done. start held high -> done pulses every 20 cycles.
- rst asserted in the 3rd SETTLE cycle -> next cycle B = 0x00, BN = 0xFF, busy = 0, no done. A new start then converts Vin = 0x3C to result 0x3C.
- Parameter build with SAMPLE_CYC = 4, SETTLE_CYC = 3 -> sample high for 4 cycles, cmp_en high for 1 of every 4 bit cycles, done at start+37.
- With SAR_CTRL_CMP_ERR_EN, force cmp_p = cmp_m = 0 in the bit-3 DECIDE -> cmp_err = 1 with done, B[3] = 0. Next clean conversion -> cmp_err = 0.

Source files
------------

// File: rtl/sar_ctrl_pkg.sv
// Shared types and default sizing for the SAR conversion sequencer.
// Optional comparator-error reporting in the top is enabled by defining SAR_CTRL_CMP_ERR_EN.
package sar_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SAMPLE = 3'd1,
        ST_SETTLE = 3'd2,
        ST_DECIDE = 3'd3,
        ST_DONE   = 3'd4
    } state_t;

    localparam int DEF_N_BITS     = 8;
    localparam int DEF_SAMPLE_CYC = 2;
    localparam int DEF_SETTLE_CYC = 1;

    // Width needed to hold the values 0 .. max_val.
    function automatic int cnt_width(input int max_val);
        return (max_val > 1) ? $clog2(max_val + 1) : 1;
    endfunction

endpackage

// File: rtl/sar_cycle_timer.sv
// Loadable down-counter with a zero flag; times the sample and settle phases.
// A load wins over counting, and the count parks at zero until reloaded.
module sar_cycle_timer #(
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         zero
);

    logic [W-1:0] count;

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (count != '0) begin
            count <= count - W'(1);
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/sar_conv_ctrl.sv
// SAR ADC conversion sequencer: sample phase, then MSB-first binary search on B/BN.
// Define SAR_CTRL_CMP_ERR_EN to add the cmp_err output flagging illegal comparator decisions.
module sar_conv_ctrl
    import sar_ctrl_pkg::*;
#(
    parameter int N_BITS     = DEF_N_BITS,
    parameter int SAMPLE_CYC = DEF_SAMPLE_CYC,
    parameter int SETTLE_CYC = DEF_SETTLE_CYC
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              cmp_p,
    input  logic              cmp_m,
    output logic              sample,
    output logic              cmp_en,
    output logic [N_BITS-1:0] B,
    output logic [N_BITS-1:0] BN,
    output logic              busy,
    output logic              done,
`ifdef SAR_CTRL_CMP_ERR_EN
    output logic              cmp_err,
`endif
    output logic [N_BITS-1:0] result
);

    localparam int IDX_W   = (N_BITS > 1) ? $clog2(N_BITS) : 1;
    localparam int TMR_MAX = (SAMPLE_CYC > SETTLE_CYC) ? SAMPLE_CYC - 1 : SETTLE_CYC - 1;
    localparam int TMR_W   = cnt_width(TMR_MAX);

    localparam logic [IDX_W-1:0] IDX_MSB   = IDX_W'(N_BITS - 1);
    localparam logic [TMR_W-1:0] SAMPLE_LD = TMR_W'(SAMPLE_CYC - 1);
    localparam logic [TMR_W-1:0] SETTLE_LD = TMR_W'(SETTLE_CYC - 1);

    state_t              state;
    logic [IDX_W-1:0]    idx;
    logic                tmr_load;
    logic [TMR_W-1:0]    tmr_val;
    logic                tmr_zero;
    logic                keep;
    logic [N_BITS-1:0]   decided;
`ifdef SAR_CTRL_CMP_ERR_EN
    logic                err_flag;
`endif

    sar_cycle_timer #(
        .W(TMR_W)
    ) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (tmr_load),
        .load_val (tmr_val),
        .zero     (tmr_zero)
    );

    // cmp_p has priority; "neither" and "only cmp_m" both drop the trial bit.
    always_comb begin
        case ({cmp_p, cmp_m})
            2'b10, 2'b11: keep = 1'b1;
            default:      keep = 1'b0;
        endcase
        decided      = B;
        decided[idx] = keep;
    end

    always_comb begin
        tmr_load = 1'b0;
        tmr_val  = '0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    tmr_load = 1'b1;
                    tmr_val  = SAMPLE_LD;
                end
            end
            ST_SAMPLE: begin
                if (tmr_zero) begin
                    tmr_load = 1'b1;
                    tmr_val  = SETTLE_LD;
                end
            end
            ST_DECIDE: begin
                tmr_load = 1'b1;
                tmr_val  = SETTLE_LD;
            end
            default: begin
                tmr_load = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            idx      <= '0;
            B        <= '0;
            result   <= '0;
            sample   <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            cmp_en   <= 1'b0;
`ifdef SAR_CTRL_CMP_ERR_EN
            err_flag <= 1'b0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    B <= '0;
                    if (start) begin
                        state  <= ST_SAMPLE;
                        idx    <= IDX_MSB;
                        sample <= 1'b1;
                        busy   <= 1'b1;
`ifdef SAR_CTRL_CMP_ERR_EN
                        err_flag <= 1'b0;
`endif
                    end
                end
                ST_SAMPLE: begin
                    if (tmr_zero) begin
                        state          <= ST_SETTLE;
                        sample         <= 1'b0;
                        B[N_BITS-1]    <= 1'b1;
                    end
                end
                ST_SETTLE: begin
                    if (tmr_zero) begin
                        state  <= ST_DECIDE;
                        cmp_en <= 1'b1;
                    end
                end
                ST_DECIDE: begin
                    cmp_en <= 1'b0;
                    B      <= decided;
`ifdef SAR_CTRL_CMP_ERR_EN
                    if (cmp_p == cmp_m) begin
                        err_flag <= 1'b1;
                    end
`endif
                    // Later assignment to the next trial bit overrides the copy of decided.
                    if (idx != '0) begin
                        idx                  <= idx - IDX_W'(1);
                        B[idx - IDX_W'(1)]   <= 1'b1;
                        state                <= ST_SETTLE;
                    end else begin
                        result <= decided;
                        busy   <= 1'b0;
                        done   <= 1'b1;
                        state  <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    done  <= 1'b0;
                    B     <= '0;
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign BN = ~B;

`ifdef SAR_CTRL_CMP_ERR_EN
    assign cmp_err = err_flag;
`endif

endmodule

// File: tb/tb_sar_conv_ctrl.sv
// Self-checking bench for sar_conv_ctrl: ideal comparator, arithmetic SAR reference model,
// a default-parameter instance and a SAMPLE_CYC=4 / SETTLE_CYC=3 instance.
module tb_sar_conv_ctrl;

    localparam int NB      = 8;
    localparam int LAT1    = 2 + NB * (1 + 1) + 1;   // 19
    localparam int LAT2    = 4 + NB * (3 + 1) + 1;   // 37
    localparam int PERIOD1 = LAT1 + 1;               // start held high

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          start2 = 1'b0;
    logic [NB-1:0] vin = '0;
    logic [NB-1:0] vin2 = '0;
    logic [NB-1:0] force_mask = '0;

    logic          cmp_p, cmp_m, sample, cmp_en, busy, done;
    logic [NB-1:0] B, BN, result, trial_lsb;
    logic          cmp_p2, cmp_m2, sample2, cmp_en2, busy2, done2;
    logic [NB-1:0] B2, BN2, result2;
`ifdef SAR_CTRL_CMP_ERR_EN
    logic          cmp_err, cmp_err2;
`endif

    int checks = 0;
    int passes = 0;
    logic mon_on = 1'b0;

    // Ideal comparator; force_mask selects one trial bit whose decision reads "neither".
    assign trial_lsb = B & (~B + 8'd1);
    always_comb begin
        if (cmp_en && force_mask != '0 && trial_lsb == force_mask) begin
            cmp_p = 1'b0;
            cmp_m = 1'b0;
        end else begin
            cmp_p = (vin >= B);
            cmp_m = !(vin >= B);
        end
    end
    assign cmp_p2 = (vin2 >= B2);
    assign cmp_m2 = !(vin2 >= B2);

    sar_conv_ctrl u_dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .cmp_p   (cmp_p),
        .cmp_m   (cmp_m),
        .sample  (sample),
        .cmp_en  (cmp_en),
        .B       (B),
        .BN      (BN),
        .busy    (busy),
        .done    (done),
`ifdef SAR_CTRL_CMP_ERR_EN
        .cmp_err (cmp_err),
`endif
        .result  (result)
    );

    sar_conv_ctrl #(
        .N_BITS     (NB),
        .SAMPLE_CYC (4),
        .SETTLE_CYC (3)
    ) u_dut2 (
        .clk     (clk),
        .rst     (rst),
        .start   (start2),
        .cmp_p   (cmp_p2),
        .cmp_m   (cmp_m2),
        .sample  (sample2),
        .cmp_en  (cmp_en2),
        .B       (B2),
        .BN      (BN2),
        .busy    (busy2),
        .done    (done2),
`ifdef SAR_CTRL_CMP_ERR_EN
        .cmp_err (cmp_err2),
`endif
        .result  (result2)
    );

    // BN must mirror B in every cycle on both instances.
    always @(negedge clk) begin
        if (mon_on) begin
            checks++;
            if (BN !== ~B) $display("FAIL bn_inv t=%0t BN=%h required=%h", $time, BN, ~B);
            else passes++;
            checks++;
            if (BN2 !== ~B2) $display("FAIL bn_inv2 t=%0t BN=%h required=%h", $time, BN2, ~B2);
            else passes++;
        end
    end

    // Reference: binary search over the code space, trial bit k forced low if fm[k].
    logic [NB-1:0] exp_tr [NB];
    logic [NB-1:0] exp_code;
    task automatic model_conv(input logic [NB-1:0] v, input logic [NB-1:0] fm);
        logic [NB-1:0] code, tr;
        code = '0;
        for (int k = NB - 1; k >= 0; k--) begin
            tr = code | (8'd1 << k);
            exp_tr[NB-1-k] = tr;
            if (!fm[k] && v >= tr) code = tr;
        end
        exp_code = code;
    endtask

    // Captured by convert()
    int            lat, busy_cnt, sample_cnt, cmpen_cnt;
    logic [NB-1:0] got_tr [NB];
    logic [NB-1:0] got_result;
    logic          got_err;
    logic          done_after, busy_after;

    // Called at a negedge with the DUT idle; returns at the negedge after DONE.
    task automatic convert(input logic [NB-1:0] v, input logic [NB-1:0] fm);
        vin = v;
        force_mask = fm;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat = -1; busy_cnt = 0; sample_cnt = 0; cmpen_cnt = 0;
        got_result = 'x; got_err = 1'bx;
        for (int k = 1; k <= 80; k++) begin
            if (busy) busy_cnt++;
            if (sample) sample_cnt++;
            if (cmp_en) begin
                if (cmpen_cnt < NB) got_tr[cmpen_cnt] = B;
                cmpen_cnt++;
            end
            if (done) begin
                lat = k;
                got_result = result;
`ifdef SAR_CTRL_CMP_ERR_EN
                got_err = cmp_err;
`endif
                break;
            end
            @(negedge clk);
        end
        @(negedge clk);
        done_after = done;
        busy_after = busy;
        force_mask = '0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (B !== 8'h00) $display("FAIL reset_B got=%h required=00", B); else passes++;
        checks++; if (BN !== 8'hFF) $display("FAIL reset_BN got=%h required=ff", BN); else passes++;
        checks++; if (result !== 8'h00) $display("FAIL reset_result got=%h required=00", result); else passes++;
        checks++;
        if ({sample, busy, done, cmp_en} !== 4'b0000)
            $display("FAIL reset_ctrl got=%b required=0000", {sample, busy, done, cmp_en});
        else passes++;
`ifdef SAR_CTRL_CMP_ERR_EN
        checks++; if (cmp_err !== 1'b0) $display("FAIL reset_cmp_err got=%b required=0", cmp_err); else passes++;
`endif
        rst = 1'b0;
        mon_on = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic();
        convert(8'hA5, '0);
        checks++; if (lat !== LAT1) $display("FAIL basic_latency got=%0d required=%0d", lat, LAT1); else passes++;
        checks++; if (got_result !== 8'hA5) $display("FAIL basic_result got=%h required=a5", got_result); else passes++;
        checks++; if (busy_cnt !== LAT1 - 1) $display("FAIL basic_busy got=%0d required=%0d", busy_cnt, LAT1 - 1); else passes++;
        checks++; if (sample_cnt !== 2) $display("FAIL basic_sample got=%0d required=2", sample_cnt); else passes++;
        checks++; if (cmpen_cnt !== NB) $display("FAIL basic_cmp_en got=%0d required=%0d", cmpen_cnt, NB); else passes++;
        checks++; if (done_after !== 1'b0) $display("FAIL basic_done_width got=%b required=0", done_after); else passes++;
        checks++; if (result !== 8'hA5) $display("FAIL basic_result_hold got=%h required=a5", result); else passes++;
    endtask

    task automatic test_extremes();
        logic [NB-1:0] vals [2];
        vals[0] = 8'hFF;
        vals[1] = 8'h00;
        for (int i = 0; i < 2; i++) begin
            model_conv(vals[i], '0);
            convert(vals[i], '0);
            checks++;
            if (got_result !== exp_code) $display("FAIL extreme_result got=%h required=%h", got_result, exp_code);
            else passes++;
            for (int j = 0; j < NB; j++) begin
                checks++;
                if (got_tr[j] !== exp_tr[j]) $display("FAIL extreme_trial%0d got=%h required=%h", j, got_tr[j], exp_tr[j]);
                else passes++;
            end
        end
    endtask

    task automatic test_random();
        logic [NB-1:0] v;
        for (int i = 0; i < 8; i++) begin
            v = 8'($urandom_range(0, 255));
            model_conv(v, '0);
            convert(v, '0);
            checks++;
            if (got_result !== exp_code || lat !== LAT1)
                $display("FAIL random_conv vin=%h got=%h lat=%0d required=%h lat=%0d", v, got_result, lat, exp_code, LAT1);
            else passes++;
            checks++;
            if (got_tr[NB/2] !== exp_tr[NB/2]) $display("FAIL random_trial got=%h required=%h", got_tr[NB/2], exp_tr[NB/2]);
            else passes++;
        end
    endtask

    task automatic test_ignored_start();
        int ndone, first_k;
        vin = 8'h5C;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        ndone = 0; first_k = -1;
        for (int k = 1; k <= 50; k++) begin
            if (done) begin
                ndone++;
                if (first_k < 0) first_k = k;
            end
            start = (k == 5 || k == LAT1);
            @(negedge clk);
        end
        start = 1'b0;
        checks++; if (ndone !== 1) $display("FAIL ignored_start_dones got=%0d required=1", ndone); else passes++;
        checks++; if (first_k !== LAT1) $display("FAIL ignored_start_latency got=%0d required=%0d", first_k, LAT1); else passes++;
        checks++; if (busy !== 1'b0) $display("FAIL ignored_start_idle got=%b required=0", busy); else passes++;
    endtask

    task automatic test_back_to_back();
        int dk [3];
        int nd;
        vin = 8'h37;
        start = 1'b1;
        @(negedge clk);
        nd = 0;
        dk[0] = -1; dk[1] = -1; dk[2] = -1;
        for (int k = 1; k <= 100 && nd < 3; k++) begin
            if (done) begin
                dk[nd] = k;
                nd++;
            end
            if (nd < 3) @(negedge clk);
        end
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checks++; if (dk[0] !== LAT1) $display("FAIL b2b_first got=%0d required=%0d", dk[0], LAT1); else passes++;
        checks++; if (dk[1] - dk[0] !== PERIOD1) $display("FAIL b2b_period1 got=%0d required=%0d", dk[1] - dk[0], PERIOD1); else passes++;
        checks++; if (dk[2] - dk[1] !== PERIOD1) $display("FAIL b2b_period2 got=%0d required=%0d", dk[2] - dk[1], PERIOD1); else passes++;
        checks++; if (result !== 8'h37) $display("FAIL b2b_result got=%h required=37", result); else passes++;
    endtask

    task automatic test_reset_abort();
        int nsettle, ndone;
        vin = 8'hC3;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        nsettle = 0;
        for (int k = 1; k <= 30; k++) begin
            if (busy && !sample && !cmp_en) nsettle++;
            if (nsettle == 3) break;
            @(negedge clk);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++; if (nsettle !== 3) $display("FAIL abort_settle_found got=%0d required=3", nsettle); else passes++;
        checks++; if (B !== 8'h00) $display("FAIL abort_B got=%h required=00", B); else passes++;
        checks++; if (BN !== 8'hFF) $display("FAIL abort_BN got=%h required=ff", BN); else passes++;
        checks++;
        if ({busy, done, sample, cmp_en} !== 4'b0000)
            $display("FAIL abort_ctrl got=%b required=0000", {busy, done, sample, cmp_en});
        else passes++;
        ndone = 0;
        for (int k = 0; k < 25; k++) begin
            if (done || busy) ndone++;
            @(negedge clk);
        end
        checks++; if (ndone !== 0) $display("FAIL abort_no_done got=%0d required=0", ndone); else passes++;
        convert(8'h3C, '0);
        checks++; if (got_result !== 8'h3C) $display("FAIL abort_reconvert got=%h required=3c", got_result); else passes++;
        checks++; if (lat !== LAT1) $display("FAIL abort_reconvert_lat got=%0d required=%0d", lat, LAT1); else passes++;
    endtask

    task automatic test_forced_decision();
        logic [NB-1:0] v;
        v = 8'($urandom_range(0, 255)) | 8'h08;
        model_conv(v, 8'h08);
        convert(v, 8'h08);
        checks++; if (got_result !== exp_code) $display("FAIL forced_result vin=%h got=%h required=%h", v, got_result, exp_code); else passes++;
        checks++; if (got_result[3] !== 1'b0) $display("FAIL forced_bit3 got=%b required=0", got_result[3]); else passes++;
`ifdef SAR_CTRL_CMP_ERR_EN
        checks++; if (got_err !== 1'b1) $display("FAIL forced_cmp_err got=%b required=1", got_err); else passes++;
`endif
        convert(v, '0);
        checks++; if (got_result !== v) $display("FAIL clean_result got=%h required=%h", got_result, v); else passes++;
`ifdef SAR_CTRL_CMP_ERR_EN
        checks++; if (got_err !== 1'b0) $display("FAIL clean_cmp_err got=%b required=0", got_err); else passes++;
`endif
    endtask

    task automatic test_params();
        logic [NB-1:0] v, res;
        int lat2, s, b, c, last_ce, gap_bad;
        v = 8'($urandom_range(0, 255));
        model_conv(v, '0);
        vin2 = v;
        start2 = 1'b1;
        @(negedge clk);
        start2 = 1'b0;
        lat2 = -1; s = 0; b = 0; c = 0; last_ce = 0; gap_bad = 0; res = 'x;
        for (int k = 1; k <= 120; k++) begin
            if (busy2) b++;
            if (sample2) s++;
            if (cmp_en2) begin
                if (c > 0 && k - last_ce != 4) gap_bad++;
                last_ce = k;
                c++;
            end
            if (done2) begin
                lat2 = k;
                res = result2;
                break;
            end
            @(negedge clk);
        end
        @(negedge clk);
        checks++; if (lat2 !== LAT2) $display("FAIL params_latency got=%0d required=%0d", lat2, LAT2); else passes++;
        checks++; if (s !== 4) $display("FAIL params_sample got=%0d required=4", s); else passes++;
        checks++; if (b !== LAT2 - 1) $display("FAIL params_busy got=%0d required=%0d", b, LAT2 - 1); else passes++;
        checks++; if (c !== NB) $display("FAIL params_cmp_en_count got=%0d required=%0d", c, NB); else passes++;
        checks++; if (gap_bad !== 0) $display("FAIL params_cmp_en_spacing got=%0d required=0", gap_bad); else passes++;
        checks++; if (res !== exp_code) $display("FAIL params_result got=%h required=%h", res, exp_code); else passes++;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_extremes();
        test_random();
        test_ignored_start();
        test_back_to_back();
        test_reset_abort();
        test_forced_decision();
        test_params();
        mon_on = 1'b0;
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
